// File: rtl/seg7_scan_capture.sv
// Capture side of a multiplexed seven-segment scan bus.
// Waits for each digit-select/segment pair to settle, decodes the segments to hex,
// tracks frame completion and select errors, and exposes the results over a Wishbone slave.
module seg7_scan_capture #(
    parameter int DIGITS        = 10,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [DIGITS-1:0] disp_sel_i,
    input  logic [7:0]        disp_segm_i,
    output logic              frame_irq_o
);
    localparam int         SW       = DIGITS + 8;
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic {IDLE, ACK} bus_state_t;

    logic [SW-1:0]     sync1, sync2, prev;
    logic [7:0]        cnt, cnt_nxt;
    logic              armed, armed_nxt, capture;
    logic [DIGITS-1:0] sel, seen, seen_nxt;
    logic [7:0]        segm;
    logic              sel_onehot, sel_multi, frame_complete;
    logic [4:0]        dec;
    logic [15:0]       dec_word;
    logic [15:0]       digit [DIGITS];
    logic [15:0]       frame_count;
    logic              frame_done;
    logic [7:0]        err_count;
    bus_state_t        state, state_nxt;
    logic              req, wr_en, clr_done, clr_err;
    logic [3:0]        idx;
    logic [31:0]       rdata;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign sel        = sync2[SW-1:8];
    assign segm       = sync2[7:0];
    assign sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign sel_multi  = (sel != '0) && !sel_onehot;
    assign dec        = decode(segm[6:0]);
    // {raw segm, 0, valid, dp, hex_ok, hex}
    assign dec_word   = {segm, 1'b0, 1'b1, segm[7], dec};

    // Stability tracking on the next-state count so the capture lands on the
    // same edge the count reaches STABLE_CYCLES.
    always_comb begin
        cnt_nxt   = cnt;
        armed_nxt = armed;
        if (sync2 == prev) begin
            if (cnt != STABLE_C) cnt_nxt = cnt + 8'd1;
        end else begin
            cnt_nxt   = 8'd1;
            armed_nxt = 1'b1;
        end
        capture        = armed_nxt && (cnt_nxt == STABLE_C);
        seen_nxt       = seen | ((capture && sel_onehot) ? sel : '0);
        frame_complete = capture && sel_onehot && (&seen_nxt);
    end

    // Synchronizer, stability counter and armed flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= {disp_sel_i, disp_segm_i};
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_nxt;
            armed <= armed_nxt && !capture;
        end
    end

    // Digit registers, seen bitmap, frame and error bookkeeping; set beats clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DIGITS; i++) digit[i] <= '0;
            seen        <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            err_count   <= '0;
            frame_irq_o <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++)
                if (capture && sel_onehot && sel[i]) digit[i] <= dec_word;
            seen        <= frame_complete ? '0 : seen_nxt;
            frame_irq_o <= frame_complete;
            if (frame_complete) begin
                frame_count <= frame_count + 16'd1;
                frame_done  <= 1'b1;
            end else if (clr_done) begin
                frame_done  <= 1'b0;
            end
            if (capture && sel_multi) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (clr_err) begin
                err_count <= '0;
            end
        end
    end

    assign req      = wbs_cyc_i && wbs_stb_i && (state == IDLE);
    assign idx      = wbs_adr_i[5:2];
    assign wr_en    = req && wbs_we_i && (idx == 4'd12);
    assign clr_done = wr_en && wbs_sel_i[2] && wbs_dat_i[16];
    assign clr_err  = wr_en && wbs_sel_i[3] && wbs_dat_i[24];

    // Read mux from current (pre-capture) register values.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == 4'(i)) rdata = {16'b0, digit[i]};
        if (idx == 4'd12) rdata = {err_count, 7'b0, frame_done, frame_count};
        if (idx == 4'd13) rdata = {{(32-DIGITS){1'b0}}, seen};
    end

    // Bus FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Bus FSM next state and ack.
    always_comb begin
        state_nxt = state;
        wbs_ack_o = 1'b0;
        case (state)
            IDLE: if (wbs_cyc_i && wbs_stb_i) state_nxt = ACK;
            ACK: begin
                wbs_ack_o = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data held only for the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)  wbs_dat_o <= '0;
        else if (req)  wbs_dat_o <= rdata;
        else           wbs_dat_o <= '0;
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with a read-data scoreboard.
module tb_seg7_scan_capture;
    localparam int DIGITS = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              stb, cyc, we;
    logic [3:0]        bsel;
    logic [31:0]       wdat, adr;
    logic              ack;
    logic [31:0]       rdat;
    logic [DIGITS-1:0] dsel;
    logic [7:0]        dsegm;
    logic              irq;

    int checks   = 0;
    int failures = 0;
    int irq_cnt  = 0;
    int irq_base;
    logic [31:0] exp_q [$];
    logic [7:0]  pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(bsel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .disp_sel_i(dsel),
        .disp_segm_i(dsegm), .frame_irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq === 1'b1) irq_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pins(input logic [DIGITS-1:0] s, input logic [7:0] g);
        dsel  = s;
        dsegm = g;
    endtask

    // One bus transaction; expects ack exactly one cycle after the request.
    task automatic bus(input string tag, input logic w, input logic [3:0] idx,
                       input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp);
        int n;
        if (!w) exp_q.push_back(exp);
        cyc = 1'b1; stb = 1'b1; we = w; bsel = be; wdat = d;
        adr = {26'b0, idx, 2'b0};
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (ack !== 1'b1 && n < 20);
        check({tag, "_ack_lat"}, 32'(n), 32'd1);
        if (!w) check(tag, rdat, exp_q.pop_front());
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; bsel = '0; wdat = '0; adr = '0;
        pins('0, 8'h00);
        tick(3);
        rst = 1'b0;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        bus("rst_digit0", 1'b0, 4'd0, 4'hF, 0, 32'h0);
        bus("rst_status", 1'b0, 4'd12, 4'hF, 0, 32'h0);
        bus("rst_seen", 1'b0, 4'd13, 4'hF, 0, 32'h0);
        check("rst_dat_after_ack", rdat, 32'd0);

        // Long hold of one digit: single capture.
        pins(10'h001, 8'h3F); tick(8);
        bus("digit0", 1'b0, 4'd0, 4'hF, 0, 32'h00003F50);
        bus("seen_d0", 1'b0, 4'd13, 4'hF, 0, 32'h001);
        pins('0, 8'h00); tick(8);

        // Too short a hold: no capture.
        pins(10'h002, 8'h06); tick(3);
        pins('0, 8'h00); tick(10);
        bus("digit1_short", 1'b0, 4'd1, 4'hF, 0, 32'h0);
        bus("seen_short", 1'b0, 4'd13, 4'hF, 0, 32'h001);

        // Full scan 0..9.
        irq_base = irq_cnt;
        for (int i = 0; i < 10; i++) begin
            pins(10'(1 << i), pat[i]); tick(6);
        end
        pins('0, 8'h00); tick(2);
        check("scan_irq_cnt", 32'(irq_cnt - irq_base), 32'd1);
        bus("scan_status", 1'b0, 4'd12, 4'hF, 0, 32'h00010001);
        bus("scan_seen", 1'b0, 4'd13, 4'hF, 0, 32'h0);
        bus("digit9", 1'b0, 4'd9, 4'hF, 0, 32'h00006F59);
        bus("digit3", 1'b0, 4'd3, 4'hF, 0, 32'h00004F53);

        // Multi-hot select, then undecodable pattern.
        pins(10'h003, 8'h3F); tick(12);
        pins(10'h004, 8'h00); tick(6);
        bus("err_status", 1'b0, 4'd12, 4'hF, 0, 32'h01010001);
        bus("digit2_bad", 1'b0, 4'd2, 4'hF, 0, 32'h00000040);
        bus("wr_clr_err", 1'b1, 4'd12, 4'b1000, 32'h01000000, 0);
        bus("err_cleared", 1'b0, 4'd12, 4'hF, 0, 32'h00010001);
        bus("unmapped", 1'b0, 4'd14, 4'hF, 0, 32'h0);

        // Frame completion coinciding with a frame_done clear.
        irq_base = irq_cnt;
        for (int i = 0; i < 9; i++) begin
            pins(10'(1 << i), pat[i]); tick(6);
        end
        pins(10'h200, pat[9]); tick(5);
        bus("wr_clr_done_race", 1'b1, 4'd12, 4'b0100, 32'h00010000, 0);
        pins('0, 8'h00); tick(2);
        check("race_irq_cnt", 32'(irq_cnt - irq_base), 32'd1);
        bus("race_status", 1'b0, 4'd12, 4'hF, 0, 32'h00010002);
        bus("wr_clr_done", 1'b1, 4'd12, 4'b0100, 32'h00010000, 0);
        bus("done_cleared", 1'b0, 4'd12, 4'hF, 0, 32'h00000002);

        // Reset during the ack cycle.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd48;
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_dat", rdat, 32'd0);
        #1 rst = 1'b0;
        tick(1);
        bus("midrst_status", 1'b0, 4'd12, 4'hF, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
